inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised successor to the fetch-to-issue op queue. Buffers decoded-instruction words between instruction fetch and issue.
- Both sides use a valid/ready handshake, so the consumer can stall pops. Every one of the DEPTH entries is usable.
- Reports occupancy and a programmable almost-full threshold. Fetch uses the threshold to throttle early.
- A branch-mispredict flush empties the queue in one cycle.

Parameters:
- DATA_W, 88: width of one packed instruction entry (op, rd, rs1, rs2, imm, flags, addr).
- DEPTH, 16: number of entries. Must be a power of two and at least 2.
- AF_THRESH, 12: almost_full asserts when count >= AF_THRESH. Legal range is 1..DEPTH.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter. Derived; do not override.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready. When 0, the queue is paused.
- flush_in  input  1  mispredict flush. Empties the queue.
- in_valid  input  1  producer presents an entry.
- in_data  input  DATA_W  entry to push.
- in_ready  output  1  queue can accept an entry.
- out_valid  output  1  head entry is valid.
- out_data  output  DATA_W  head entry (show-ahead).
- out_ready  input  1  consumer accepts the head entry.
- count  output  CNT_W  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- empty  output  1  count == 0.

Behaviour:
- State: storage array mem[DEPTH], head and tail pointers of $clog2(DEPTH) bits wrapping naturally, and a count register.
- Reset (rst_in=1 at an edge): head=tail=count=0. Immediately after, out_valid=0, out_data=0, in_ready=1, empty=1, full=0, almost_full=0.
- Reset overrides rdy_in and flush_in. Storage contents need not be cleared.
- Flush (flush_in=1, rst_in=0): same effect as reset on head, tail and count. Applies regardless of rdy_in. Any push or pop in that cycle is discarded.
- Pause (rdy_in=0, no reset or flush): no push, no pop, all state holds. in_ready is forced to 0. out_valid and out_data keep showing the current head.
- Output signals, all combinational from registered state (apart from the rdy_in gate on in_ready):
  - out_valid = (count != 0).
  - out_data = mem[head] when out_valid, else all zeros.
  - in_ready = rdy_in && !full. in_ready must not depend combinationally on out_ready or in_valid.
  - full, empty and almost_full are decoded from count.
- push = rdy_in && in_valid && in_ready. Writes mem[tail] <= in_data and sets tail <= tail+1 (mod DEPTH).
- pop = rdy_in && out_valid && out_ready. Sets head <= head+1 (mod DEPTH).
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Simultaneous push and pop with count=1: the pop returns the old head. The new entry becomes the head next cycle, so out_valid stays 1.
- No write-to-read bypass. An entry pushed into an empty queue appears on out_data one cycle after the push edge.
- Full with out_ready=1: the pop proceeds. The push is refused because in_ready=0. in_ready rises the next cycle.
- in_valid while in_ready=0: ignored. The producer must hold in_data and in_valid.
- Pointer wrap: after DEPTH pushes and DEPTH pops, the head entry is still returned correctly. Pointers roll from DEPTH-1 to 0 with no special case.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- Latency: push to earliest observation at the head is 1 cycle. Pop to the next head being visible is 1 cycle.

Test Plan:
- Fill and drain (DEPTH=4, AF_THRESH=3):
  - Push 0xA1..0xA4 on consecutive cycles with out_ready=0. Expect count 1,2,3,4; almost_full rises when count=3; full=1 and in_ready=0 at count 4.
  - Then out_ready=1. Expect out_data A1,A2,A3,A4 on successive cycles, ending with empty=1 and out_data=0.
- Streaming at count=1: push and pop every cycle for 10 cycles with values 0..9. Expect count to stay 1 and out_data to equal the value pushed one cycle earlier, with no gaps.
- Full plus pop: at count=4, assert in_valid=1 (0xB5) and out_ready=1 together.
  - Expect A1 popped, 0xB5 not accepted, count=3.
  - Next cycle 0xB5 is accepted and count returns to 4.
- Pause: with count=2, hold rdy_in=0 for 3 cycles while in_valid=1 and out_ready=1. Expect count=2, the head unchanged and in_ready=0. Then raise rdy_in and expect normal operation to resume.
- Flush mid-stream: with count=3 and a push and pop in the same cycle, assert flush_in=1.
  - Next cycle: count=0, out_valid=0, out_data=0.
  - A following push of 0xC0 appears at the head one cycle later.
- Wrap and reset: run 9 push/pop pairs so the pointers wrap twice, checking FIFO order. Then assert rst_in mid-stream with rdy_in=0 and expect all reset values on the next cycle.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue
// ----------------------------------------------------------------------------
// Buffers decoded-instruction words between instruction fetch and issue.
// Both sides use a valid/ready handshake. All DEPTH entries are usable, and
// the head entry is presented show-ahead on out_data. A mispredict flush
// empties the queue in a single cycle. Occupancy and an almost-full flag
// (count >= AF_THRESH) let fetch throttle before the queue fills.
//
// Ports
//   clk_in       system clock, rising edge
//   rst_in       synchronous active-high reset (overrides rdy_in / flush_in)
//   rdy_in       global ready; 0 pauses the queue (no push, no pop)
//   flush_in     mispredict flush; empties the queue, discards push/pop
//   in_valid     producer presents an entry
//   in_data      entry to push
//   in_ready     queue can accept an entry (rdy_in && !full)
//   out_valid    head entry is valid (count != 0)
//   out_data     head entry, zero when empty
//   out_ready    consumer accepts the head entry
//   count        occupied entries, 0..DEPTH
//   full         count == DEPTH
//   almost_full  count >= AF_THRESH
//   empty        count == 0
// ============================================================================
module inst_fetch_queue #(
    parameter int DATA_W    = 88,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              almost_full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Status decode, all from registered state. in_ready only looks at
    // rdy_in and the count, never at the consumer side, so there is no
    // combinational path from out_ready / in_valid to in_ready.
    // ------------------------------------------------------------------
    assign count       = count_reg;
    assign full        = (count_reg == CNT_FULL);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= CNT_AF);
    assign in_ready    = rdy_in && !full;
    assign out_valid   = !empty;

    // Show-ahead head: the array is read asynchronously so the head is
    // visible the cycle after it was written (no write-to-read bypass).
    assign out_data    = out_valid ? mem[head_reg] : '0;

    assign push = rdy_in && in_valid && in_ready;
    assign pop  = rdy_in && out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state for pointers and occupancy. Pointers are PTR_W wide, so
    // they wrap from DEPTH-1 to 0 on their own (DEPTH is a power of two).
    // ------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_in) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = tail_reg + PTR_ONE;
            end
            if (pop) begin
                head_next = head_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage is never cleared; a write landing in a flush/reset cycle is
    // suppressed so the discarded entry cannot reappear later.
    always_ff @(posedge clk_in) begin
        if (push && !flush_in && !rst_in) begin
            mem[tail_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// tb_inst_fetch_queue
// ----------------------------------------------------------------------------
// Scoreboard bench for inst_fetch_queue at DEPTH=4, AF_THRESH=3. Accepted
// pushes are queued in sb; pops compare the head against the queue front.
// After every clock the full output set is compared against the scoreboard
// state, plus targeted checks for each scenario.
// ============================================================================
module tb_inst_fetch_queue;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush_in;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sb [$];

    always #5 clk_in = ~clk_in;

    inst_fetch_queue #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the scoreboard's idea of the queue.
    task automatic check_state(input string tag);
        int            sz;
        logic [DW-1:0] hd;
        sz = sb.size();
        hd = (sz != 0) ? sb[0] : '0;
        check({tag, "_count"},  32'(count),       32'(sz));
        check({tag, "_ovalid"}, 32'(out_valid),   32'(sz != 0));
        check({tag, "_odata"},  32'(out_data),    32'(hd));
        check({tag, "_iready"}, 32'(in_ready),    32'(rdy_in && (sz < DEPTH)));
        check({tag, "_full"},   32'(full),        32'(sz == DEPTH));
        check({tag, "_afull"},  32'(almost_full), 32'(sz >= AF));
        check({tag, "_empty"},  32'(empty),       32'(sz == 0));
    endtask

    // One clock: settle the scoreboard from the inputs driven now, then
    // check the outputs #1 after the edge.
    task automatic step(input string tag);
        int            sz;
        logic [DW-1:0] exp_d;
        sz = sb.size();
        if (rst_in || flush_in) begin
            sb.delete();
            $display("[TB] %s: %s", tag, rst_in ? "reset" : "flush");
        end else if (rdy_in) begin
            if ((sz != 0) && out_ready) begin
                exp_d = sb.pop_front();
                $display("[TB] %s: pop  0x%0h (expect 0x%0h)", tag, out_data, exp_d);
                check({tag, "_pop"}, 32'(out_data), 32'(exp_d));
            end
            if (in_valid && (sz < DEPTH)) begin
                sb.push_back(in_data);
                $display("[TB] %s: push 0x%0h", tag, in_data);
            end
        end
        @(posedge clk_in);
        #1;
        check_state(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset
        step("rst");
        step("rst");
        rst_in = 1'b0;
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_odata",  32'(out_data), 32'd0);

        // Fill 0xA1..0xA4 with the consumer stalled
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(16'hA1 + i);
            step("fill");
            check("fill_cnt", 32'(count), 32'(i + 1));
            check("fill_af",  32'(almost_full), 32'(i >= 2));
        end
        check("fill_full",   32'(full),     32'd1);
        check("fill_iready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_head", 32'(out_data), 32'(16'hA1 + i));
            step("drain");
        end
        check("drain_empty", 32'(empty),    32'd1);
        check("drain_odata", 32'(out_data), 32'd0);

        // Streaming at count=1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0050;
        step("preload");
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'(i);
            step("stream");
            check("stream_cnt",  32'(count),    32'd1);
            check("stream_head", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        step("stream_end");

        // Full plus pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(16'hA1 + i);
            step("refill");
        end
        in_data   = 16'h00B5;
        out_ready = 1'b1;
        check("fp_iready", 32'(in_ready), 32'd0);
        step("fullpop");
        check("fp_cnt",  32'(count),    32'd3);
        check("fp_head", 32'(out_data), 32'h00A2);
        check("fp_iready_rise", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step("fp_accept");
        check("fp_cnt2", 32'(count), 32'd4);

        // Bring count to 2, then pause
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step("to2");
        step("to2");
        rdy_in   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h00D1;
        for (int i = 0; i < 3; i++) begin
            step("pause");
            check("pause_cnt",    32'(count),    32'd2);
            check("pause_head",   32'(out_data), 32'h00A4);
            check("pause_iready", 32'(in_ready), 32'd0);
        end
        rdy_in = 1'b1;
        step("resume");
        check("resume_head", 32'(out_data), 32'h00B5);
        check("resume_cnt",  32'(count),    32'd2);

        // Flush mid-stream at count=3
        out_ready = 1'b0;
        in_data   = 16'h00D2;
        step("to3");
        check("to3_cnt", 32'(count), 32'd3);
        in_data   = 16'h00D3;
        out_ready = 1'b1;
        flush_in  = 1'b1;
        step("flush");
        check("flush_cnt",    32'(count),     32'd0);
        check("flush_ovalid", 32'(out_valid), 32'd0);
        check("flush_odata",  32'(out_data),  32'd0);
        flush_in  = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'h00C0;
        step("post_flush");
        check("pf_head", 32'(out_data), 32'h00C0);

        // Wrap: 9 push/pop pairs at count=1
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = DW'(16'h00E0 + i);
            step("wrap");
            check("wrap_head", 32'(out_data), 32'(16'h00E0 + i));
        end

        // Reset mid-stream while paused
        rst_in = 1'b1;
        rdy_in = 1'b0;
        step("rst2");
        check("rst2_cnt",    32'(count),       32'd0);
        check("rst2_ovalid", 32'(out_valid),   32'd0);
        check("rst2_odata",  32'(out_data),    32'd0);
        check("rst2_empty",  32'(empty),       32'd1);
        check("rst2_full",   32'(full),        32'd0);
        check("rst2_af",     32'(almost_full), 32'd0);
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst2_iready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
